// File: rtl/axil_pkg.sv
// Shared AXI-Lite definitions: master FSM state encodings and response codes.
// Used by the master, the memory slave and the bench.
package axil_pkg;

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StRdAddr = 3'd1;
    localparam logic [2:0] StRdData = 3'd2;
    localparam logic [2:0] StWrReq  = 3'd3;
    localparam logic [2:0] StWrResp = 3'd4;
    localparam logic [2:0] StRsp    = 3'd5;

    localparam int unsigned RESP_OKAY = 0;

endpackage

// File: rtl/axil_lite_master.sv
// Single-outstanding AXI-Lite master: one command in, one AXI-Lite transaction out,
// bounded retry on error responses, result held on the rsp port until taken.
module axil_lite_master
    import axil_pkg::*;
#(
    parameter int unsigned ADDR_WDTH = 4,
    parameter int unsigned DATA_WDTH = 32,
    parameter int unsigned RESP_WDTH = 1,
    parameter int unsigned MAX_RETRY = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_we,
    input  logic [ADDR_WDTH-1:0] cmd_addr,
    input  logic [DATA_WDTH-1:0] cmd_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATA_WDTH-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic [1:0]           rsp_tries,
    output logic                 ar_valid,
    input  logic                 ar_ready,
    output logic [ADDR_WDTH-1:0] ar_address,
    input  logic                 r_valid,
    output logic                 r_ready,
    input  logic [DATA_WDTH-1:0] r_data,
    input  logic [RESP_WDTH-1:0] r_resp,
    output logic                 aw_valid,
    input  logic                 aw_ready,
    output logic [ADDR_WDTH-1:0] aw_address,
    output logic                 w_valid,
    input  logic                 w_ready,
    output logic [DATA_WDTH-1:0] w_data,
    input  logic                 b_valid,
    output logic                 b_ready,
    input  logic [RESP_WDTH-1:0] b_resp
);

    // Wide enough to hold MAX_RETRY, never zero bits.
    localparam int unsigned CntW = $clog2(MAX_RETRY + 2);

    logic [2:0]           state_q, state_d;
    logic [ADDR_WDTH-1:0] addr_q, addr_d;
    logic [DATA_WDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WDTH-1:0] rdata_q, rdata_d;
    logic                 err_q, err_d;
    logic [CntW-1:0]      retry_q, retry_d;
    logic                 aw_done_q, aw_done_d;
    logic                 w_done_q, w_done_d;
    logic                 resp_bad;
    logic [2:0]           retry_st;
    logic [31:0]          tries_ext;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        retry_d   = retry_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        resp_bad  = 1'b0;
        retry_st  = StIdle;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    addr_d    = cmd_addr;
                    wdata_d   = cmd_wdata;
                    rdata_d   = '0;
                    err_d     = 1'b0;
                    retry_d   = '0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = cmd_we ? StWrReq : StRdAddr;
                end
            end
            StRdAddr: begin
                if (ar_ready) state_d = StRdData;
            end
            StRdData: begin
                if (r_valid) begin
                    if (r_resp == RESP_WDTH'(RESP_OKAY)) begin
                        rdata_d = r_data;
                        state_d = StRsp;
                    end else begin
                        resp_bad = 1'b1;
                        retry_st = StRdAddr;
                    end
                end
            end
            StWrReq: begin
                // Each channel finishes on its own handshake; a done channel stops asserting valid.
                aw_done_d = aw_done_q | aw_ready;
                w_done_d  = w_done_q | w_ready;
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = StWrResp;
                end
            end
            StWrResp: begin
                if (b_valid) begin
                    if (b_resp == RESP_WDTH'(RESP_OKAY)) begin
                        state_d = StRsp;
                    end else begin
                        resp_bad = 1'b1;
                        retry_st = StWrReq;
                    end
                end
            end
            StRsp: begin
                if (rsp_ready) begin
                    retry_d = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (resp_bad) begin
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            if (retry_q < CntW'(MAX_RETRY)) begin
                retry_d = retry_q + CntW'(1);
                state_d = retry_st;
            end else begin
                err_d   = 1'b1;
                rdata_d = '0;
                state_d = StRsp;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            retry_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            retry_q   <= retry_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    always_comb begin
        tries_ext  = 32'(retry_q);
        rsp_tries  = (tries_ext > 32'd3) ? 2'd3 : tries_ext[1:0];
        cmd_ready  = (state_q == StIdle);
        ar_valid   = (state_q == StRdAddr);
        r_ready    = (state_q == StRdData);
        aw_valid   = (state_q == StWrReq) && !aw_done_q;
        w_valid    = (state_q == StWrReq) && !w_done_q;
        b_ready    = (state_q == StWrResp);
        rsp_valid  = (state_q == StRsp);
        ar_address = addr_q;
        aw_address = addr_q;
        w_data     = wdata_q;
        rsp_rdata  = rdata_q;
        rsp_err    = err_q;
    end

endmodule

// File: tb/tb_axil_lite_master.sv
// Bench for axil_lite_master: behavioural memory slave with per-channel wait states,
// directed commands and a scoreboard of expected responses.
module tb_axil_lite_master;
    import axil_pkg::*;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned RW = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_tries;
    logic          ar_valid, ar_ready, r_valid, r_ready;
    logic [AW-1:0] ar_address;
    logic [DW-1:0] r_data;
    logic [RW-1:0] r_resp;
    logic          aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
    logic [AW-1:0] aw_address;
    logic [DW-1:0] w_data;
    logic [RW-1:0] b_resp;

    axil_lite_master #(
        .ADDR_WDTH(AW),
        .DATA_WDTH(DW),
        .RESP_WDTH(RW),
        .MAX_RETRY(2)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_tries(rsp_tries),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_address(ar_address),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_address(aw_address),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp)
    );

    always #5 clk = ~clk;

    // ---------------- memory slave model ----------------
    logic          always_error = 1'b0;
    int            aw_wait = 0, w_wait = 0;
    int            aw_cnt = 0, w_cnt = 0;
    int            ar_hs_n = 0, aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0;
    logic [DW-1:0] mem [16];
    logic          aw_got = 1'b0, w_got = 1'b0;
    logic [AW-1:0] aw_addr_s;
    logic [DW-1:0] w_data_s;

    assign ar_ready = 1'b1;
    assign aw_ready = aw_valid && (aw_cnt >= aw_wait);
    assign w_ready  = w_valid && (w_cnt >= w_wait);

    always @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            b_valid <= 1'b0;
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
            aw_cnt  <= 0;
            w_cnt   <= 0;
        end else begin
            if (ar_valid && ar_ready) begin
                r_valid <= 1'b1;
                r_data  <= always_error ? '0 : mem[ar_address];
                r_resp  <= always_error;
                ar_hs_n <= ar_hs_n + 1;
            end else if (r_valid && r_ready) begin
                r_valid <= 1'b0;
            end
            if (aw_valid && aw_ready) begin
                aw_got    <= 1'b1;
                aw_addr_s <= aw_address;
                aw_cnt    <= 0;
                aw_hs_n   <= aw_hs_n + 1;
            end else if (aw_valid) begin
                aw_cnt <= aw_cnt + 1;
            end
            if (w_valid && w_ready) begin
                w_got    <= 1'b1;
                w_data_s <= w_data;
                w_cnt    <= 0;
                w_hs_n   <= w_hs_n + 1;
            end else if (w_valid) begin
                w_cnt <= w_cnt + 1;
            end
            if ((aw_got || (aw_valid && aw_ready)) && (w_got || (w_valid && w_ready))) begin
                b_valid <= 1'b1;
                b_resp  <= always_error;
                if (!always_error) mem[aw_got ? aw_addr_s : aw_address] <= w_got ? w_data_s : w_data;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end
            if (b_valid && b_ready) begin
                b_valid <= 1'b0;
                b_hs_n  <= b_hs_n + 1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        logic [1:0]    tries;
        string         name;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endfunction

    task automatic monitor();
        logic ar_p = 1'b0, aw_p = 1'b0, w_p = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            // A valid still waiting at the last cycle must still be up now.
            if (ar_p) check("ar_valid_hold", ar_valid, 1);
            if (aw_p) check("aw_valid_hold", aw_valid, 1);
            if (w_p)  check("w_valid_hold", w_valid, 1);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rsp_unexpected: got rdata %h err %b, required no response",
                             rsp_rdata, rsp_err);
                end else begin
                    e = exp_q.pop_front();
                    check({e.name, "_rdata"}, rsp_rdata, e.rdata);
                    check({e.name, "_err"}, 32'(rsp_err), 32'(e.err));
                    check({e.name, "_tries"}, 32'(rsp_tries), 32'(e.tries));
                end
            end
            ar_p = ar_valid && !ar_ready && !rst;
            aw_p = aw_valid && !aw_ready && !rst;
            w_p  = w_valid && !w_ready && !rst;
        end
    endtask

    // Presents a command until accepted; returns 1 ns after the accepting edge.
    task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic want_rsp, input logic [DW-1:0] er, input logic ee,
                         input logic [1:0] et, input string nm);
        exp_t e;
        int   t = 0;
        logic hs;
        if (want_rsp) begin
            e.rdata = er;
            e.err   = ee;
            e.tries = et;
            e.name  = nm;
            exp_q.push_back(e);
        end
        cmd_we    = we;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_valid = 1'b1;
        do begin
            @(negedge clk);
            hs = cmd_ready;
            @(posedge clk);
            t++;
        end while (!hs && t < 50);
        #1 cmd_valid = 1'b0;
        if (!hs) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_accept: got no cmd_ready in 50 cycles, required acceptance", nm);
        end
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d responses outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    int a0, aw0, w0, b0, t;

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b1;
        fork
            monitor();
        join_none
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_valids", {ar_valid, aw_valid, w_valid, r_ready, b_ready, rsp_valid}, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        @(posedge clk);
        #1;

        // Load mem[3] through the master, then the latency read.
        issue(1'b1, 4'h3, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0, 2'd0, "wr3");
        drain();
        issue(1'b0, 4'h3, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 2'd0, "rd3");
        @(negedge clk);
        check("lat_c1_ar_valid", ar_valid, 1);
        check("lat_c1_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        check("lat_c2_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        check("lat_c3_rsp_valid", rsp_valid, 1);
        drain();

        // Write then read back.
        issue(1'b1, 4'hA, 32'h12345678, 1'b1, 32'h0, 1'b0, 2'd0, "wrA");
        drain();
        issue(1'b0, 4'hA, 32'h0, 1'b1, 32'h12345678, 1'b0, 2'd0, "rdA");
        drain();

        // AW accepted three cycles before W.
        w_wait = 3;
        aw0 = aw_hs_n;
        w0  = w_hs_n;
        b0  = b_hs_n;
        issue(1'b1, 4'h5, 32'hCAFEF00D, 1'b1, 32'h0, 1'b0, 2'd0, "wr5_skew");
        @(negedge clk);
        check("skew_c1_aw_valid", aw_valid, 1);
        check("skew_c1_w_valid", w_valid, 1);
        @(negedge clk);
        check("skew_c2_aw_valid", aw_valid, 0);
        check("skew_c2_w_valid", w_valid, 1);
        drain();
        check("skew_aw_hs", aw_hs_n - aw0, 1);
        check("skew_w_hs", w_hs_n - w0, 1);
        check("skew_b_hs", b_hs_n - b0, 1);
        w_wait = 0;
        issue(1'b0, 4'h5, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0, 2'd0, "rd5");
        drain();

        // Slave always errors: initial try plus two retries, then failure.
        always_error = 1'b1;
        a0 = ar_hs_n;
        issue(1'b0, 4'h3, 32'h0, 1'b1, 32'h0, 1'b1, 2'd2, "rd_err");
        drain();
        check("err_ar_hs", ar_hs_n - a0, 3);
        always_error = 1'b0;

        // Response back-pressure with a second command already waiting.
        rsp_ready = 1'b0;
        issue(1'b0, 4'hA, 32'h0, 1'b1, 32'h12345678, 1'b0, 2'd0, "rd_hold");
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!rsp_valid && t < 20);
        check("hold_rsp_seen", rsp_valid, 1);
        @(posedge clk);
        #1;
        exp_q.push_back('{rdata: 32'hDEADBEEF, err: 1'b0, tries: 2'd0, name: "rd_after"});
        cmd_we    = 1'b0;
        cmd_addr  = 4'h3;
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_rsp_valid", rsp_valid, 1);
            check("hold_rsp_rdata", rsp_rdata, 32'h12345678);
            check("hold_cmd_ready", cmd_ready, 0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        check("hold_cmd_ready_hs", cmd_ready, 0);
        @(posedge clk);
        @(negedge clk);
        check("after_cmd_ready", cmd_ready, 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        check("after_ar_valid", ar_valid, 1);
        drain();

        // Reset while waiting in WR_RESP.
        issue(1'b1, 4'h7, 32'h55AA55AA, 1'b0, 32'h0, 1'b0, 2'd0, "wr_rst");
        @(posedge clk);
        #1;
        check("rst_mid_b_ready", b_ready, 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_valids", {ar_valid, aw_valid, w_valid, r_ready, b_ready, rsp_valid}, 0);
        check("rst_mid_cmd_ready", cmd_ready, 1);
        repeat (3) begin
            @(negedge clk);
            check("rst_mid_no_rsp", rsp_valid, 0);
        end
        check("final_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
